ws2812_decoder: RTL and testbench
=================================

WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Parameter HIGH_THRESH, default 60: high-phase length in cycles at or above which a bit decodes as 1; 0.6 us at 100 MHz.
REQ-002 Parameter MIN_HIGH, default 20: high phases shorter than this are glitches.
REQ-003 Parameter MAX_HIGH, default 120: high phases longer than this are stuck-high faults.
REQ-004 Parameter LATCH_CYCLES, default 5000: low time that counts as the strand latch/reset; 50 us.
REQ-005 Parameter IDX_WIDTH, default 8: width of the pixel index and count.
REQ-006 clk_in  input  1  single system clock, 100 MHz; all logic is in this domain.
REQ-007 rst_in  input  1  asynchronous, active-low reset; asserts asynchronously and releases on clk_in.
REQ-008 strand_in  input  1  one-wire WS2812 data line; asynchronous to clk_in.
REQ-009 green_out, red_out, blue_out  output  8 each  decoded colour of the last complete pixel.
REQ-010 pixel_index  output  IDX_WIDTH  position of the decoded pixel within the frame, 0-based.
REQ-011 pixel_valid  output  1  one-cycle strobe; colour and pixel_index are valid in that cycle.
REQ-012 frame_done  output  1  one-cycle strobe on latch detection after at least one received bit.
REQ-013 frame_pixels  output  IDX_WIDTH  count of complete pixels in the frame; valid with frame_done.
REQ-014 error_out  output  1  one-cycle strobe on a protocol error.
REQ-015 error_code  output  2  error cause, valid with error_out: 01 short high, 10 long high, 11 partial pixel at latch.

Function
REQ-016 strand_in passes through a 2-flop synchronizer to give s; all timing below is in cycles of s.
REQ-017 States: ARM, LOW, HIGH; one counter cnt, saturating at max(LATCH_CYCLES, MAX_HIGH+1).
REQ-018 ARM: cnt counts consecutive cycles with s=0 and clears when s=1; at cnt=LATCH_CYCLES go to LOW with bit_cnt=0 and pixel count=0; no strobes.
REQ-019 LOW, s=1: go to HIGH with cnt=1.
REQ-020 LOW, s=0: cnt increments; at cnt=LATCH_CYCLES take the latch action (REQ-025) and stay in LOW, cnt held saturated.
REQ-021 HIGH, s=1: cnt increments; at cnt=MAX_HIGH+1, error_out=1 with code 10, then go to ARM.
REQ-022 HIGH, s=0 with cnt<MIN_HIGH: error_out=1 with code 01, then go to ARM; the shift register and counts are discarded.
REQ-023 HIGH, s=0 otherwise: bit=(cnt>=HIGH_THRESH); shift it MSB-first into a 24-bit register in G7..G0, R7..R0, B7..B0 order; bit_cnt++; go to LOW with cnt=1.
REQ-024 On the 24th bit, in the same edge as REQ-023:
- load green_out/red_out/blue_out and pixel_index=pixel count;
- pulse pixel_valid;
- bit_cnt=0; pixel count increments, saturating at 2^IDX_WIDTH-1.
REQ-025 Latch action:
- if any bit arrived since the last latch, pulse frame_done with frame_pixels=pixel count;
- if additionally bit_cnt!=0, pulse error_out with code 11 in the same cycle;
- clear bit_cnt and pixel count.
REQ-026 Latency: pixel_valid asserts exactly one cycle after the first s=0 sample that ends the 24th high phase; frame_done asserts the cycle cnt reaches LATCH_CYCLES.
REQ-027 Low-phase length is not checked beyond latch detection; any low shorter than LATCH_CYCLES is an inter-bit gap.
REQ-028 Colour outputs and pixel_index hold their values between strobes.
REQ-029 At most one strobe of each kind per cycle; strobes never last more than one cycle.

Reset
REQ-030 While rst_in=0: state=ARM, cnt=0, bit_cnt=0, pixel count=0, synchronizer flops=0, all outputs 0.
REQ-031 Reset mid-frame discards partial data; after release the block requires LATCH_CYCLES of low before decoding, so a partially seen bit or pixel is never emitted.

Verification
REQ-032 Hold low 5000 cycles, then send 0xFF0000 as 24 bits (1 = 80 high/45 low, 0 = 40 high/85 low), then 5000 low -> one pixel_valid with green=FF, red=00, blue=00, index 0; frame_done with frame_pixels=1.
REQ-033 Two pixels 0x123456 then 0xABCDEF, then latch -> pixel_valid at index 0 (G=12, R=34, B=56) and index 1 (G=AB, R=CD, B=EF); frame_pixels=2; no error.
REQ-034 10-cycle high pulse mid-pixel -> error_out with code 01; the next pixel is ignored until a full latch, then the following pixel decodes at index 0.
REQ-035 Line held high 200 cycles -> error_out with code 10 at the 121st high cycle; no pixel_valid.
REQ-036 12 bits then latch -> frame_done with frame_pixels=0 and error_out with code 11 in the same cycle.
REQ-037 Assert rst_in after bit 10 of a pixel, release, then send a full frame -> all outputs 0 during reset; no pulses until 5000 low cycles; the next pixel decodes correctly at index 0.

Source files
------------

// File: rtl/ws2812_decoder_if.sv
// Decoded WS2812 pixel/frame/error bundle; the line driver side is master, the decoder is slave.
interface ws2812_decoder_if #(
  parameter int IDX_WIDTH = 8
);
  logic                 strand_in;
  logic [7:0]           green_out;
  logic [7:0]           red_out;
  logic [7:0]           blue_out;
  logic [IDX_WIDTH-1:0] pixel_index;
  logic                 pixel_valid;
  logic                 frame_done;
  logic [IDX_WIDTH-1:0] frame_pixels;
  logic                 error_out;
  logic [1:0]           error_code;

  modport master (
    output strand_in,
    input  green_out, red_out, blue_out, pixel_index, pixel_valid,
    input  frame_done, frame_pixels, error_out, error_code
  );

  modport slave (
    input  strand_in,
    output green_out, red_out, blue_out, pixel_index, pixel_valid,
    output frame_done, frame_pixels, error_out, error_code
  );
endinterface

// File: rtl/ws2812_decoder.sv
// WS2812 one-wire decoder: classifies high-phase lengths into bits, assembles GRB pixels,
// detects the latch gap and flags glitches, stuck-high lines and partial pixels.
module ws2812_decoder #(
  parameter int HIGH_THRESH  = 60,
  parameter int MIN_HIGH     = 20,
  parameter int MAX_HIGH     = 120,
  parameter int LATCH_CYCLES = 5000,
  parameter int IDX_WIDTH    = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ws2812_decoder_if.slave    bus
);

  localparam int CNT_MAX = (LATCH_CYCLES > MAX_HIGH + 1) ? LATCH_CYCLES : MAX_HIGH + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
  localparam logic [CW-1:0] LATCH_C = CW'(LATCH_CYCLES);
  localparam logic [CW-1:0] HI_T    = CW'(HIGH_THRESH);
  localparam logic [CW-1:0] MIN_H   = CW'(MIN_HIGH);
  localparam logic [CW-1:0] MAX_H1  = CW'(MAX_HIGH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_PARTIAL = 2'b11;

  logic                 sync1_q, sync2_q;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                 seen_q, seen_d;
  logic [23:0]          shift_q, shift_d;
  logic [7:0]           green_q, green_d;
  logic [7:0]           red_q, red_d;
  logic [7:0]           blue_q, blue_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 pv_q, pv_d;
  logic                 fd_q, fd_d;
  logic [IDX_WIDTH-1:0] fp_q, fp_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic                 s;
  logic [CW-1:0]        cnt_inc;
  logic [23:0]          shift_nx;
  logic [IDX_WIDTH-1:0] pix_inc;

  assign s        = sync2_q;
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign shift_nx = {shift_q[22:0], (cnt_q >= HI_T)};
  assign pix_inc  = (pix_cnt_q == {IDX_WIDTH{1'b1}}) ? pix_cnt_q : pix_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    seen_d    = seen_q;
    shift_d   = shift_q;
    green_d   = green_q;
    red_d     = red_q;
    blue_d    = blue_q;
    idx_d     = idx_q;
    pv_d      = 1'b0;
    fd_d      = 1'b0;
    fp_d      = fp_q;
    err_d     = 1'b0;
    code_d    = code_q;

    case (state_q)
      ST_ARM: begin
        // Decoding only starts once a full latch gap has been seen, so a bit or
        // pixel caught halfway after reset or an error can never be emitted.
        if (s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LATCH_C) begin
            state_d   = ST_LOW;
            bit_cnt_d = '0;
            pix_cnt_d = '0;
            seen_d    = 1'b0;
          end
        end
      end

      ST_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end else if (cnt_q < LATCH_C) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == LATCH_C) begin
            if (seen_q) begin
              fd_d = 1'b1;
              fp_d = pix_cnt_q;
              if (bit_cnt_q != 5'd0) begin
                err_d  = 1'b1;
                code_d = ERR_PARTIAL;
              end
            end
            bit_cnt_d = '0;
            pix_cnt_d = '0;
            seen_d    = 1'b0;
          end
        end
      end

      ST_HIGH: begin
        if (s) begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_H1) begin
            err_d     = 1'b1;
            code_d    = ERR_LONG;
            state_d   = ST_ARM;
            cnt_d     = '0;
            bit_cnt_d = '0;
            pix_cnt_d = '0;
            seen_d    = 1'b0;
          end
        end else if (cnt_q < MIN_H) begin
          err_d     = 1'b1;
          code_d    = ERR_SHORT;
          state_d   = ST_ARM;
          cnt_d     = CNT_ONE;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          seen_d    = 1'b0;
        end else begin
          shift_d = shift_nx;
          seen_d  = 1'b1;
          state_d = ST_LOW;
          cnt_d   = CNT_ONE;
          if (bit_cnt_q == 5'd23) begin
            green_d   = shift_nx[23:16];
            red_d     = shift_nx[15:8];
            blue_d    = shift_nx[7:0];
            idx_d     = pix_cnt_q;
            pv_d      = 1'b1;
            bit_cnt_d = '0;
            pix_cnt_d = pix_inc;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_ARM;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      seen_q    <= 1'b0;
      shift_q   <= '0;
      green_q   <= '0;
      red_q     <= '0;
      blue_q    <= '0;
      idx_q     <= '0;
      pv_q      <= 1'b0;
      fd_q      <= 1'b0;
      fp_q      <= '0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      sync1_q   <= bus.strand_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      seen_q    <= seen_d;
      shift_q   <= shift_d;
      green_q   <= green_d;
      red_q     <= red_d;
      blue_q    <= blue_d;
      idx_q     <= idx_d;
      pv_q      <= pv_d;
      fd_q      <= fd_d;
      fp_q      <= fp_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign bus.green_out    = green_q;
  assign bus.red_out      = red_q;
  assign bus.blue_out     = blue_q;
  assign bus.pixel_index  = idx_q;
  assign bus.pixel_valid  = pv_q;
  assign bus.frame_done   = fd_q;
  assign bus.frame_pixels = fp_q;
  assign bus.error_out    = err_q;
  assign bus.error_code   = code_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: table-driven pixel frames plus hand-written
// sequences for latency, glitch, stuck-high, partial-pixel and mid-frame reset cases.
module tb_ws2812_decoder;

  logic clk_in;
  logic rst_in;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   dbl;
  int   last_low_cyc;

  ws2812_decoder_if #(.IDX_WIDTH(8)) bus ();

  ws2812_decoder #(
    .HIGH_THRESH (60),
    .MIN_HIGH    (20),
    .MAX_HIGH    (120),
    .LATCH_CYCLES(5000),
    .IDX_WIDTH   (8)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] g, r, b, idx;
    int         cyc;
  } pix_ev_t;

  typedef struct {
    logic [7:0] n;
    logic       err11;
    int         cyc;
  } frm_ev_t;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } err_ev_t;

  typedef struct {
    logic [23:0] word;
    logic [7:0]  g, r, b, idx;
  } vec_t;

  pix_ev_t pq[$];
  frm_ev_t fq[$];
  err_ev_t eq[$];
  logic    prev_pv, prev_fd, prev_err;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (bus.pixel_valid)
      pq.push_back('{bus.green_out, bus.red_out, bus.blue_out, bus.pixel_index, cyc});
    if (bus.frame_done)
      fq.push_back('{bus.frame_pixels, bus.error_out && (bus.error_code == 2'b11), cyc});
    if (bus.error_out)
      eq.push_back('{bus.error_code, cyc});
    if ((bus.pixel_valid && prev_pv) || (bus.frame_done && prev_fd) || (bus.error_out && prev_err))
      dbl++;
    prev_pv  = bus.pixel_valid;
    prev_fd  = bus.frame_done;
    prev_err = bus.error_out;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to have finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    bus.strand_in = lvl;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? 80 : 40);
    last_low_cyc = cyc;
    hold(1'b0, b ? 45 : 85);
  endtask

  task automatic send_bits(input logic [23:0] word, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) send_bit(word[i]);
  endtask

  task automatic clear_q();
    pq.delete();
    fq.delete();
    eq.delete();
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.green_out, bus.red_out, bus.blue_out, bus.pixel_index, bus.pixel_valid,
                bus.frame_done, bus.frame_pixels, bus.error_out, bus.error_code});
  endfunction

  initial begin
    vec_t tbl[2];
    int   c0;

    tbl[0] = '{24'h123456, 8'h12, 8'h34, 8'h56, 8'd0};
    tbl[1] = '{24'hABCDEF, 8'hAB, 8'hCD, 8'hEF, 8'd1};

    n_cmp = 0; n_bad = 0; dbl = 0; cyc = 0;
    prev_pv = 1'b0; prev_fd = 1'b0; prev_err = 1'b0;
    bus.strand_in = 1'b0;
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", out_vec(), 64'd0);
    rst_in = 1'b1;
    hold(1'b0, 5010);
    check("idle_no_events", 64'(pq.size() + fq.size() + eq.size()), 64'd0);

    // Single pixel 0xFF0000 with latency checks.
    clear_q();
    send_bits(24'hFF0000, 24);
    hold(1'b0, 5010);
    check("p1_count", 64'(pq.size()), 64'd1);
    check("p1_frames", 64'(fq.size()), 64'd1);
    check("p1_errors", 64'(eq.size()), 64'd0);
    if (pq.size() == 1) begin
      check("p1_green", 64'(pq[0].g), 64'hFF);
      check("p1_red", 64'(pq[0].r), 64'h00);
      check("p1_blue", 64'(pq[0].b), 64'h00);
      check("p1_index", 64'(pq[0].idx), 64'd0);
      check("p1_latency", 64'(pq[0].cyc - last_low_cyc), 64'd3);
    end
    if (fq.size() == 1) begin
      check("p1_frame_pixels", 64'(fq[0].n), 64'd1);
      check("p1_frame_err11", 64'(fq[0].err11), 64'd0);
      check("p1_frame_latency", 64'(fq[0].cyc - last_low_cyc), 64'd5002);
    end
    check("p1_hold", 64'({bus.green_out, bus.red_out, bus.blue_out, bus.pixel_index}),
          64'({8'hFF, 8'h00, 8'h00, 8'd0}));

    // Table frame: each entry is one pixel of the same frame.
    clear_q();
    for (int i = 0; i < 2; i++) send_bits(tbl[i].word, 24);
    hold(1'b0, 5010);
    check("tbl_count", 64'(pq.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (pq.size() > i) begin
        check("tbl_green", 64'(pq[i].g), 64'(tbl[i].g));
        check("tbl_red", 64'(pq[i].r), 64'(tbl[i].r));
        check("tbl_blue", 64'(pq[i].b), 64'(tbl[i].b));
        check("tbl_index", 64'(pq[i].idx), 64'(tbl[i].idx));
      end
    end
    check("tbl_frames", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) check("tbl_frame_pixels", 64'(fq[0].n), 64'd2);
    check("tbl_errors", 64'(eq.size()), 64'd0);

    // Glitch mid-pixel: data is dropped until a fresh latch gap.
    clear_q();
    send_bits(24'hF0F0F0, 5);
    hold(1'b1, 10);
    hold(1'b0, 45);
    send_bits(24'h00FF00, 8);
    hold(1'b0, 5010);
    check("gl_errors", 64'(eq.size()), 64'd1);
    if (eq.size() == 1) check("gl_code", 64'(eq[0].code), 64'h1);
    check("gl_ignored_pixels", 64'(pq.size() + fq.size()), 64'd0);
    clear_q();
    send_bits(24'h5A5AA5, 24);
    hold(1'b0, 5010);
    check("gl_next_count", 64'(pq.size()), 64'd1);
    if (pq.size() == 1)
      check("gl_next_pixel", 64'({pq[0].g, pq[0].r, pq[0].b, pq[0].idx}),
            64'({8'h5A, 8'h5A, 8'hA5, 8'd0}));
    check("gl_next_frames", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) check("gl_next_frame_pixels", 64'(fq[0].n), 64'd1);

    // Stuck-high line.
    clear_q();
    c0 = cyc;
    hold(1'b1, 200);
    hold(1'b0, 5010);
    check("sh_errors", 64'(eq.size()), 64'd1);
    if (eq.size() == 1) begin
      check("sh_code", 64'(eq[0].code), 64'h2);
      check("sh_latency", 64'(eq[0].cyc - c0), 64'd123);
    end
    check("sh_no_pixels", 64'(pq.size() + fq.size()), 64'd0);

    // Partial pixel at latch.
    clear_q();
    send_bits(24'hC0FFEE, 12);
    hold(1'b0, 5010);
    check("pp_frames", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) begin
      check("pp_frame_pixels", 64'(fq[0].n), 64'd0);
      check("pp_err11_same_cycle", 64'(fq[0].err11), 64'd1);
    end
    check("pp_errors", 64'(eq.size()), 64'd1);
    if (eq.size() == 1) check("pp_code", 64'(eq[0].code), 64'h3);
    check("pp_no_pixels", 64'(pq.size()), 64'd0);

    // Reset after bit 10 of a pixel.
    clear_q();
    send_bits(24'hFFFFFF, 10);
    rst_in = 1'b0;
    hold(1'b0, 3);
    check("rst_mid_outputs", out_vec(), 64'd0);
    rst_in = 1'b1;
    hold(1'b0, 100);
    send_bits(24'hFFFFFF, 6);
    hold(1'b0, 5010);
    check("rst_no_early_events", 64'(pq.size() + fq.size() + eq.size()), 64'd0);
    send_bits(24'hC33C81, 24);
    hold(1'b0, 5010);
    check("rst_count", 64'(pq.size()), 64'd1);
    if (pq.size() == 1)
      check("rst_pixel", 64'({pq[0].g, pq[0].r, pq[0].b, pq[0].idx}),
            64'({8'hC3, 8'h3C, 8'h81, 8'd0}));
    check("rst_frames", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) check("rst_frame_pixels", 64'(fq[0].n), 64'd1);
    check("rst_errors", 64'(eq.size()), 64'd0);

    check("single_cycle_strobes", 64'(dbl), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
